// File: rtl/serial_adder64_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder64_ctrl_pkg
//  Description : Shared constants and state encoding for the digit-serial
//                add/subtract controller.
//                c_SLICE       bits handled per step (ripple slice width)
//                c_WIDTH       default operand width
//                c_STEPS       steps per operation at default width
//                c_CNT_W       step counter width at default width
//                state_t       IDLE / RUN / DONE, 2-bit encoding
//                steps_for()   steps needed for an arbitrary width
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder64_ctrl_pkg;

    localparam int c_SLICE = 4;
    localparam int c_WIDTH = 64;
    localparam int c_STEPS = c_WIDTH / c_SLICE;
    localparam int c_CNT_W = $clog2(c_STEPS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int steps_for(input int width);
        return width / c_SLICE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder64_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder64_ctrl_if
//  Description : Request/result bundle for the serial adder controller.
//                Request : in_valid, in_ready, a, b, sub, cin
//                Result  : out_valid, out_ready, sum, cout, ovf
//                Status  : busy
//                master  : requester/consumer side (drives operands, out_ready)
//                slave   : controller side
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder64_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder64_ctrl_full_adder4.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder4
//  Description : 4-bit ripple-carry slice (FullAdder4).
//                i_a, i_b  slice operands
//                i_cin     carry into bit 0
//                o_s       slice sum
//                o_cout    carry out of bit 3
//                o_c3      carry into bit 3 (for signed overflow detection)
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder4 (
    input  wire logic [3:0] i_a,
    input  wire logic [3:0] i_b,
    input  wire logic       i_cin,
    output logic      [3:0] o_s,
    output logic            o_cout,
    output logic            o_c3
);
    logic [4:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign o_s[i]     = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_c[4];
    assign o_c3   = w_c[3];
endmodule
`default_nettype wire

// File: rtl/serial_adder64_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder64_ctrl
//  Description : Digit-serial WIDTH-bit add/subtract. One 4-bit ripple slice
//                is reused over WIDTH/4 cycles, LSB slice first.
//                clk   rising-edge clock
//                rst   synchronous active-high reset
//                bus   slave view of serial_adder64_ctrl_if:
//                      in_valid/in_ready + a, b, sub, cin  (request)
//                      out_valid/out_ready + sum, cout, ovf (result)
//                      busy (RUN or DONE)
//                WIDTH must be a multiple of 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder64_ctrl
    import serial_adder64_ctrl_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  wire logic              clk,
    input  wire logic              rst,
    serial_adder64_ctrl_if.slave   bus
);
    localparam int c_NSTEP = steps_for(WIDTH);
    localparam int c_CW    = (c_NSTEP > 1) ? $clog2(c_NSTEP) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_busy;
    logic               w_accept;
    logic               w_last;
    logic [3:0]         w_s;
    logic               w_co;
    logic               w_c3;

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_last   = (r_cnt == c_CW'(c_NSTEP - 1));

    // Slice operands always come from the bottom of the shift registers.
    full_adder4 u_fa4 (
        .i_a    (r_a[3:0]),
        .i_b    (r_b[3:0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_co),
        .o_c3   (w_c3)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath. The sum is built by shifting each slice result in from the
    // top, so after the final step slice k sits at bits [4k+3:4k].
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b ^ {WIDTH{bus.sub}};
            r_carry <= bus.sub | bus.cin;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a     <= r_a >> c_SLICE;
            r_b     <= r_b >> c_SLICE;
            r_sum   <= {w_s, r_sum[WIDTH-1:c_SLICE]};
            r_carry <= w_co;
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= w_co ^ w_c3;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + c_CW'(1);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_serial_adder64_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder64_ctrl
//  Description : Self-checking bench for serial_adder64_ctrl. Expected results
//                come from a plain-arithmetic model; a monitor compares the
//                result bus against it on every cycle out_valid is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder64_ctrl;
    localparam int c_W = 64;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [c_W-1:0] m_sum;
    logic           m_cout;
    logic           m_ovf;
    logic           m_active;

    serial_adder64_ctrl_if #(.WIDTH(c_W)) bus ();

    serial_adder64_ctrl #(.WIDTH(c_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [c_W-1:0] act, input logic [c_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: a + (sub ? ~b : b) + (sub | cin) in WIDTH+1 bits; signed
    // overflow when both addends share a sign that the result does not.
    task automatic model(input logic [c_W-1:0] ta, input logic [c_W-1:0] tb_in,
                         input logic ts, input logic tc);
        logic [c_W-1:0] bb;
        logic [c_W:0]   full;
        bb     = ts ? ~tb_in : tb_in;
        full   = {1'b0, ta} + {1'b0, bb} + {{c_W{1'b0}}, (ts | tc)};
        m_sum  = full[c_W-1:0];
        m_cout = full[c_W];
        m_ovf  = (ta[c_W-1] == bb[c_W-1]) && (full[c_W-1] != ta[c_W-1]);
    endtask

    // Result monitor.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (m_active) begin
                chk("mon_sum",  bus.sum,  m_sum);
                chk("mon_cout", {63'd0, bus.cout}, {63'd0, m_cout});
                chk("mon_ovf",  {63'd0, bus.ovf},  {63'd0, m_ovf});
            end else begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid actual=1 required=0");
            end
        end
    end

    task automatic do_op(input logic [c_W-1:0] ta, input logic [c_W-1:0] tb_in,
                         input logic ts, input logic tc,
                         input logic [c_W-1:0] es, input logic ec, input logic eo,
                         input int hold);
        int n;
        model(ta, tb_in, ts, tc);
        chk("model_sum",  m_sum, es);
        chk("model_cout", {63'd0, m_cout}, {63'd0, ec});
        chk("model_ovf",  {63'd0, m_ovf},  {63'd0, eo});
        @(negedge clk);
        chk("in_ready_idle", {63'd0, bus.in_ready}, 64'd1);
        bus.a        = ta;
        bus.b        = tb_in;
        bus.sub      = ts;
        bus.cin      = tc;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        m_active     = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = ~ta;
        bus.b        = 64'hDEAD_BEEF_0BAD_F00D;
        bus.sub      = ~ts;
        bus.cin      = ~tc;
        chk("busy_run", {63'd0, bus.busy}, 64'd1);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 64'(n), 64'd16);
        chk("lit_sum",  bus.sum, es);
        chk("lit_cout", {63'd0, bus.cout}, {63'd0, ec});
        chk("lit_ovf",  {63'd0, bus.ovf},  {63'd0, eo});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid",    {63'd0, bus.out_valid}, 64'd1);
            chk("hold_in_ready", {63'd0, bus.in_ready},  64'd0);
            chk("hold_sum",      bus.sum, es);
            bus.in_valid = (i == 3);
            bus.a        = 64'h1111;
            bus.b        = 64'h2222;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        m_active      = 1'b0;
        chk("post_valid",    {63'd0, bus.out_valid}, 64'd0);
        chk("post_in_ready", {63'd0, bus.in_ready},  64'd1);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        m_active      = 1'b0;
        m_sum         = '0;
        m_cout        = 1'b0;
        m_ovf         = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_busy",      {63'd0, bus.busy},      64'd0);
        chk("rst_sum",       bus.sum, 64'd0);
        chk("rst_cout",      {63'd0, bus.cout}, 64'd0);
        chk("rst_ovf",       {63'd0, bus.ovf},  64'd0);

        // out_ready while idle must be harmless
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("idle_ready_noeffect", {63'd0, bus.out_valid}, 64'd0);

        do_op(64'h1, 64'h1, 1'b0, 1'b0, 64'h2, 1'b0, 1'b0, 0);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 0);
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 0);
        do_op(64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0);
        do_op(64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 1'b1, 1'b0, 10);
        do_op(64'hF, 64'h1, 1'b0, 1'b1, 64'h11, 1'b0, 1'b0, 0);
        do_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0);

        // Abort at RUN step 7
        @(negedge clk);
        bus.a        = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.b        = 64'h1;
        bus.sub      = 1'b0;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("abort_sum",       bus.sum, 64'd0);
        chk("abort_in_ready",  {63'd0, bus.in_ready}, 64'd1);
        chk("abort_busy",      {63'd0, bus.busy},     64'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_result", {63'd0, bus.out_valid}, 64'd0);

        do_op(64'h3, 64'h4, 1'b0, 1'b0, 64'h7, 1'b0, 1'b0, 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
